// File: rtl/popcnt_frame_acc.sv
`default_nettype none
// ============================================================================
//  Module   : popcnt_frame_acc
//  Purpose  : Counts the set bits of each input word in a registered stage,
//             then sums the counts over a last-framed stream. Emits one
//             saturating {sum, beats, ovf} result per frame over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module popcnt_frame_acc #(
   parameter int DATA_W = 128,
   parameter int ACC_W  = 24,
   parameter int BEAT_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_last_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [ACC_W-1:0]  out_sum_o,
   output logic [BEAT_W-1:0] out_beats_o,
   output logic              out_ovf_o
);

   localparam int c_NPART = DATA_W / 16;
   localparam int c_CNT_W = $clog2(DATA_W) + 1;
   localparam int c_SUM_W = ACC_W + 1;

   logic [c_NPART*5-1:0] w_part;
   logic [c_NPART*5-1:0] r_s1_part;
   logic                 r_s1_valid;
   logic                 r_s1_last;

   logic [ACC_W-1:0]     r_acc;
   logic [BEAT_W-1:0]    r_beats;
   logic                 r_ovf;

   logic                 r_out_valid;
   logic [ACC_W-1:0]     r_out_sum;
   logic [BEAT_W-1:0]    r_out_beats;
   logic                 r_out_ovf;

   logic                 w_adv;
   logic                 w_accept;
   logic                 w_step;
   logic [c_CNT_W-1:0]   w_cnt;
   logic [c_SUM_W-1:0]   w_sum_wide;
   logic [BEAT_W:0]      w_beats_wide;
   logic [ACC_W-1:0]     w_sum_nxt;
   logic [BEAT_W-1:0]    w_beats_nxt;
   logic                 w_ovf_nxt;

   // Only a last beat waiting behind an unconsumed result stalls the pipe.
   assign w_adv    = !(r_s1_valid && r_s1_last && r_out_valid && !out_ready_i);
   assign w_accept = in_valid_i && w_adv;
   assign w_step   = r_s1_valid && w_adv;

   assign in_ready_o  = w_adv;
   assign out_valid_o = r_out_valid;
   assign out_sum_o   = r_out_sum;
   assign out_beats_o = r_out_beats;
   assign out_ovf_o   = r_out_ovf;

   // One 16-bit popcount slice per partial, registered in stage 1.
   for (genvar g = 0; g < c_NPART; g++) begin : g_part
      logic [4:0] w_pc;
      // Count the set bits of this 16-bit slice.
      always_comb begin
         w_pc = '0;
         for (int b = 0; b < 16; b++) begin
            w_pc = w_pc + 5'(in_data_i[g*16+b]);
         end
      end
      assign w_part[g*5 +: 5] = w_pc;
   end

   // Reduce the stage-1 partials to a word count and form saturating updates.
   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < c_NPART; i++) begin
         w_cnt = w_cnt + c_CNT_W'(r_s1_part[i*5 +: 5]);
      end
      w_sum_wide   = c_SUM_W'(r_acc) + c_SUM_W'(w_cnt);
      w_beats_wide = {1'b0, r_beats} + {{BEAT_W{1'b0}}, 1'b1};
      w_sum_nxt    = w_sum_wide[ACC_W] ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
      w_beats_nxt  = w_beats_wide[BEAT_W] ? {BEAT_W{1'b1}} : w_beats_wide[BEAT_W-1:0];
      w_ovf_nxt    = r_ovf | w_sum_wide[ACC_W] | w_beats_wide[BEAT_W];
   end

   // Stage 1: capture partial counts on accept; hold everything while stalled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_part  <= '0;
      end else if (w_adv) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_part <= w_part;
            r_s1_last <= in_last_i;
         end
      end
   end

   // Stage 2: accumulate over the frame and publish the result on the last beat.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_acc       <= '0;
         r_beats     <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_beats <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         if (w_step && r_s1_last) begin
            r_out_sum   <= w_sum_nxt;
            r_out_beats <= w_beats_nxt;
            r_out_ovf   <= w_ovf_nxt;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_beats     <= '0;
            r_ovf       <= 1'b0;
         end else begin
            if (out_ready_i) begin
               r_out_valid <= 1'b0;
            end
            if (w_step) begin
               r_acc   <= w_sum_nxt;
               r_beats <= w_beats_nxt;
               r_ovf   <= w_ovf_nxt;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_popcnt_frame_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_popcnt_frame_acc
//  Purpose  : Self-checking bench for popcnt_frame_acc (vector table plus
//             overflow, random-frame and mid-frame reset sequences).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_popcnt_frame_acc;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [127:0] in_data;
   logic         in_last;
   logic         out_ready;

   logic         in_ready,  out_valid,  out_ovf;
   logic [23:0]  out_sum;
   logic [15:0]  out_beats;

   logic         in_ready_b, out_valid_b, out_ovf_b;
   logic [8:0]   out_sum_b;
   logic [15:0]  out_beats_b;

   popcnt_frame_acc #(.DATA_W(128), .ACC_W(24), .BEAT_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_data_i(in_data), .in_last_i(in_last),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_sum_o(out_sum), .out_beats_o(out_beats), .out_ovf_o(out_ovf)
   );

   popcnt_frame_acc #(.DATA_W(128), .ACC_W(9), .BEAT_W(16)) dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready_b),
      .in_data_i(in_data), .in_last_i(in_last),
      .out_valid_o(out_valid_b), .out_ready_i(out_ready),
      .out_sum_o(out_sum_b), .out_beats_o(out_beats_b), .out_ovf_o(out_ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         v;
      logic [127:0] d;
      logic         l;
      logic         r;
      logic         e_rdy;
      logic         e_val;
      logic [23:0]  e_sum;
      logic [15:0]  e_beats;
      logic         e_ovf;
   } vec_t;

   vec_t         vecs [15];
   logic [127:0] ones;
   int           n_checks;
   int           n_fail;
   logic         done;
   logic [23:0]  exp_sum_q [$];
   logic [15:0]  exp_beats_q [$];
   int           got;
   logic         held;
   logic [23:0]  held_sum;
   logic [15:0]  held_beats;
   logic         held_ovf;
   int           n_res;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Present one beat and hold it until it is accepted (bounded).
   task automatic send(input logic [127:0] d, input logic l);
      logic acc;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL send timeout: in_ready stayed 0, expected 1");
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   // Wait for a posted result (bounded); returns whether one appeared.
   task automatic wait_valid(output logic seen);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_valid timeout: out_valid 0, expected 1");
      end
   endtask

   initial begin
      logic seen;
      n_checks  = 0;
      n_fail    = 0;
      done      = 1'b0;
      ones      = '1;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      //          v     d            l     r     rdy   val   sum      beats  ovf
      vecs[0]  = '{1'b1, ones,        1'b1, 1'b1, 1'b1, 1'b0, 24'd0,   16'd0, 1'b0};
      vecs[1]  = '{1'b0, 128'd0,      1'b0, 1'b1, 1'b1, 1'b1, 24'd128, 16'd1, 1'b0};
      vecs[2]  = '{1'b1, 128'hFF,     1'b0, 1'b1, 1'b1, 1'b0, 24'd128, 16'd1, 1'b0};
      vecs[3]  = '{1'b1, ones,        1'b0, 1'b1, 1'b1, 1'b0, 24'd128, 16'd1, 1'b0};
      vecs[4]  = '{1'b1, 128'd0,      1'b1, 1'b1, 1'b1, 1'b0, 24'd128, 16'd1, 1'b0};
      vecs[5]  = '{1'b1, 128'd1,      1'b1, 1'b1, 1'b1, 1'b1, 24'd136, 16'd3, 1'b0};
      vecs[6]  = '{1'b0, 128'd0,      1'b0, 1'b1, 1'b1, 1'b1, 24'd1,   16'd1, 1'b0};
      vecs[7]  = '{1'b0, 128'd0,      1'b0, 1'b1, 1'b1, 1'b0, 24'd1,   16'd1, 1'b0};
      vecs[8]  = '{1'b1, ones,        1'b1, 1'b0, 1'b1, 1'b0, 24'd1,   16'd1, 1'b0};
      vecs[9]  = '{1'b1, 128'd3,      1'b1, 1'b0, 1'b1, 1'b1, 24'd128, 16'd1, 1'b0};
      vecs[10] = '{1'b1, ones,        1'b1, 1'b0, 1'b0, 1'b1, 24'd128, 16'd1, 1'b0};
      vecs[11] = '{1'b1, ones,        1'b1, 1'b0, 1'b0, 1'b1, 24'd128, 16'd1, 1'b0};
      vecs[12] = '{1'b1, ones,        1'b1, 1'b1, 1'b1, 1'b1, 24'd2,   16'd1, 1'b0};
      vecs[13] = '{1'b0, 128'd0,      1'b0, 1'b1, 1'b1, 1'b1, 24'd128, 16'd1, 1'b0};
      vecs[14] = '{1'b0, 128'd0,      1'b0, 1'b1, 1'b1, 1'b0, 24'd128, 16'd1, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst out_valid", 32'(out_valid), 0);
      check("rst out_sum",   32'(out_sum),   0);
      check("rst out_beats", 32'(out_beats), 0);
      check("rst out_ovf",   32'(out_ovf),   0);
      rst_n = 1'b1;
      #1;
      check("post-rst in_ready", 32'(in_ready), 1);

      // Cycle-accurate vector table
      @(posedge clk);
      #1;
      for (int i = 0; i < 15; i++) begin
         in_valid  = vecs[i].v;
         in_data   = vecs[i].d;
         in_last   = vecs[i].l;
         out_ready = vecs[i].r;
         @(negedge clk);
         check($sformatf("vec%0d in_ready", i),   32'(in_ready),   32'(vecs[i].e_rdy));
         check($sformatf("vec%0d in_ready_b", i), 32'(in_ready_b), 32'(vecs[i].e_rdy));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_val));
         check($sformatf("vec%0d out_sum", i),   32'(out_sum),   32'(vecs[i].e_sum));
         check($sformatf("vec%0d out_beats", i), 32'(out_beats), 32'(vecs[i].e_beats));
         check($sformatf("vec%0d out_ovf", i),   32'(out_ovf),   32'(vecs[i].e_ovf));
      end
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;

      // Saturation: 5 all-ones beats on the 9-bit accumulator
      out_ready = 1'b1;
      for (int b = 0; b < 5; b++) send(ones, b == 4);
      wait_valid(seen);
      check("sat sum_b",   32'(out_sum_b),   511);
      check("sat beats_b", 32'(out_beats_b), 5);
      check("sat ovf_b",   32'(out_ovf_b),   1);
      check("sat valid_b", 32'(out_valid_b), 1);
      check("wide sum",    32'(out_sum),     640);
      check("wide ovf",    32'(out_ovf),     0);
      send(128'd0, 1'b1);
      wait_valid(seen);
      check("post-sat sum_b",   32'(out_sum_b),   0);
      check("post-sat beats_b", 32'(out_beats_b), 1);
      check("post-sat ovf_b",   32'(out_ovf_b),   0);
      @(posedge clk);
      #1;

      // Random frames with random valid gaps and ready toggling
      got  = 0;
      held = 1'b0;
      fork
         begin : drv
            for (int f = 0; f < 50; f++) begin
               int           len;
               logic [127:0] words [8];
               int           s;
               if (done) break;
               len = $urandom_range(1, 8);
               s   = 0;
               for (int b = 0; b < len; b++) begin
                  words[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
                  if ($urandom_range(0, 3) == 0) words[b] = words[b] & {4{$urandom()}};
                  s += $countones(words[b]);
               end
               exp_sum_q.push_back(24'(s));
               exp_beats_q.push_back(16'(len));
               for (int b = 0; b < len; b++) begin
                  repeat ($urandom_range(0, 2)) begin
                     @(posedge clk);
                     #1;
                  end
                  if (done) break;
                  send(words[b], b == len - 1);
               end
            end
         end
         begin : rdy
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
         begin : mon
            for (int cyc = 0; cyc < 20000 && got < 50; cyc++) begin
               @(negedge clk);
               if (held) begin
                  check("hold valid", 32'(out_valid), 1);
                  check("hold sum",   32'(out_sum),   32'(held_sum));
                  check("hold beats", 32'(out_beats), 32'(held_beats));
                  check("hold ovf",   32'(out_ovf),   32'(held_ovf));
               end
               held       = out_valid && !out_ready;
               held_sum   = out_sum;
               held_beats = out_beats;
               held_ovf   = out_ovf;
               if (out_valid && out_ready) begin
                  if (exp_sum_q.size() == 0) begin
                     check("rand unexpected result", 32'(out_valid), 0);
                  end else begin
                     check($sformatf("rand%0d sum", got),   32'(out_sum),   32'(exp_sum_q.pop_front()));
                     check($sformatf("rand%0d beats", got), 32'(out_beats), 32'(exp_beats_q.pop_front()));
                     check($sformatf("rand%0d ovf", got),   32'(out_ovf),   0);
                  end
                  got++;
               end
            end
            if (got < 50) begin
               n_checks++;
               n_fail++;
               $display("FAIL rand timeout: got %0d results, expected 50", got);
            end
            done = 1'b1;
         end
      join
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-frame after 2 beats, then a single-beat frame
      send(ones, 1'b0);
      send(ones, 1'b0);
      rst_n = 1'b0;
      #2;
      check("midrst out_valid", 32'(out_valid), 0);
      check("midrst out_sum",   32'(out_sum),   0);
      check("midrst out_beats", 32'(out_beats), 0);
      check("midrst out_ovf",   32'(out_ovf),   0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(ones, 1'b1);
      n_res = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            n_res++;
            check("after-rst sum",   32'(out_sum),   128);
            check("after-rst beats", 32'(out_beats), 1);
            check("after-rst ovf",   32'(out_ovf),   0);
         end
      end
      check("after-rst result count", 32'(n_res), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
